// File: rtl/dfh_csr_responder.sv
// DFH chain CSR responder: per-feature DFH, SCRATCH and DFH read counter,
// with a single registered completion slot and ready/valid backpressure.
module dfh_csr_responder #(
   parameter int unsigned             NUM_FEAT   = 3,
   parameter logic [12*NUM_FEAT-1:0]  FEAT_ID    = {12'h014, 12'h001, 12'h000},
   parameter logic [4*NUM_FEAT-1:0]   FEAT_TYPE  = {4'h3, 4'h3, 4'h4},
   parameter logic [4*NUM_FEAT-1:0]   FEAT_MAJOR = {4'h0, 4'h0, 4'h0}
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [19:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_tag,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_data,
   output logic [7:0]  rsp_tag,
   output logic        rsp_err
);

   localparam logic [11:0] OFF_DFH     = 12'h000;
   localparam logic [11:0] OFF_SCRATCH = 12'h008;
   localparam logic [11:0] OFF_CNT     = 12'h010;
   localparam logic [31:0] CNT_MAX     = 32'hFFFF_FFFF;

   // The last feature terminates the chain: next offset 0 and eol set.
   function automatic logic [63:0] dfh_word(input int unsigned k);
      logic        last;
      logic [23:0] nxt;
      last = (k == NUM_FEAT - 32'd1);
      nxt  = last ? 24'h000000 : 24'h001000;
      return {FEAT_TYPE[4*k +: 4], 8'h00, 4'h0, 7'h00, last, nxt,
              FEAT_MAJOR[4*k +: 4], FEAT_ID[12*k +: 12]};
   endfunction

   logic [63:0] scratch_q [NUM_FEAT];
   logic [63:0] scratch_d [NUM_FEAT];
   logic [31:0] cnt_q     [NUM_FEAT];
   logic [31:0] cnt_d     [NUM_FEAT];

   logic        rsp_valid_q, rsp_valid_d;
   logic [63:0] rsp_data_q,  rsp_data_d;
   logic [7:0]  rsp_tag_q,   rsp_tag_d;
   logic        rsp_err_q,   rsp_err_d;

   logic        acc_s, rd_s, wr_s;
   logic        idx_ok_s, align_ok_s;
   logic [7:0]  idx_s;
   logic [11:0] off_s;
   logic [63:0] sel_dfh_s, sel_scratch_s;
   logic [31:0] sel_cnt_s;
   logic [63:0] rd_data_s;
   logic        rd_err_s;

   assign req_ready  = !rsp_valid_q || rsp_ready;
   assign acc_s      = req_valid && req_ready;
   assign rd_s       = acc_s && !req_write;
   assign wr_s       = acc_s && req_write;
   assign idx_s      = req_addr[19:12];
   assign off_s      = req_addr[11:0];
   assign idx_ok_s   = (32'(idx_s) < NUM_FEAT);
   assign align_ok_s = (req_addr[2:0] == 3'b000);

   // Per-feature register select, built as an AND-OR mux over all features.
   always_comb begin
      sel_dfh_s     = 64'd0;
      sel_scratch_s = 64'd0;
      sel_cnt_s     = 32'd0;
      for (int unsigned k = 0; k < NUM_FEAT; k++) begin
         sel_dfh_s     |= (idx_s == 8'(k)) ? dfh_word(k) : 64'd0;
         sel_scratch_s |= (idx_s == 8'(k)) ? scratch_q[k] : 64'd0;
         sel_cnt_s     |= (idx_s == 8'(k)) ? cnt_q[k] : 32'd0;
      end
   end

   // Read decode; an out-of-range index outranks misalignment.
   always_comb begin
      rd_data_s = 64'd0;
      rd_err_s  = 1'b0;
      if (!idx_ok_s) begin
         rd_data_s = {64{1'b1}};
         rd_err_s  = 1'b1;
      end else if (!align_ok_s) begin
         rd_data_s = 64'd0;
         rd_err_s  = 1'b1;
      end else begin
         case (off_s)
            OFF_DFH:     rd_data_s = sel_dfh_s;
            OFF_SCRATCH: rd_data_s = sel_scratch_s;
            OFF_CNT:     rd_data_s = {32'd0, sel_cnt_s};
            default:     rd_data_s = 64'd0;
         endcase
      end
   end

   // SCRATCH writes, counter clears and saturating DFH read counts.
   always_comb begin
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      for (int unsigned k = 0; k < NUM_FEAT; k++) begin
         if (wr_s && (idx_s == 8'(k)) && align_ok_s && (off_s == OFF_SCRATCH)) begin
            scratch_d[k] = req_wdata;
         end else begin
            scratch_d[k] = scratch_q[k];
         end
         if (wr_s && (idx_s == 8'(k)) && align_ok_s && (off_s == OFF_CNT)) begin
            cnt_d[k] = 32'd0;
         end else if (rd_s && (idx_s == 8'(k)) && (off_s == OFF_DFH) && (cnt_q[k] != CNT_MAX)) begin
            cnt_d[k] = cnt_q[k] + 32'd1;
         end else begin
            cnt_d[k] = cnt_q[k];
         end
      end
   end

   // Completion slot: load on read accept, clear on consume, otherwise hold.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_tag_d   = rsp_tag_q;
      rsp_err_d   = rsp_err_q;
      if (rd_s) begin
         rsp_valid_d = 1'b1;
         rsp_data_d  = rd_data_s;
         rsp_tag_d   = req_tag;
         rsp_err_d   = rd_err_s;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end else begin
         rsp_valid_d = rsp_valid_q;
      end
   end

   // Completion registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 64'd0;
         rsp_tag_q   <= 8'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_tag_q   <= rsp_tag_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Per-feature SCRATCH and counter state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < NUM_FEAT; k++) begin
            scratch_q[k] <= 64'd0;
            cnt_q[k]     <= 32'd0;
         end
      end else begin
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_tag   = rsp_tag_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dfh_csr_responder.sv
// Bench for dfh_csr_responder: directed vector table, backpressure and reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_dfh_csr_responder;

   logic        clk, rst_n;
   logic        req_valid, req_ready, req_write;
   logic [19:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_tag;
   logic        rsp_valid, rsp_ready;
   logic [63:0] rsp_data;
   logic [7:0]  rsp_tag;
   logic        rsp_err;

   int total = 0;
   int bad   = 0;

   localparam logic [63:0] DFH0 = 64'h4000_0000_1000_0000;
   localparam logic [63:0] DFH1 = 64'h3000_0000_1000_0001;
   localparam logic [63:0] DFH2 = 64'h3000_0100_0000_0014;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef struct {
      logic        wr;
      logic [19:0] addr;
      logic [63:0] wdata;
      logic [7:0]  tag;
      logic [63:0] exp_data;
      logic        exp_err;
   } vec_t;
   vec_t vecs[$];

   typedef struct {
      logic [63:0] d;
      logic [7:0]  t;
      logic        e;
   } cpl_t;
   cpl_t exp_q[$];

   logic [63:0] m_scr [3];
   logic [31:0] m_cnt [3];
   logic [11:0] offs [6] = '{12'h000, 12'h008, 12'h010, 12'h018, 12'h004, 12'hFF8};

   dfh_csr_responder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_tag   (req_tag),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_tag   (rsp_tag),
      .rsp_err   (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {63'd0, act}, {63'd0, exp});
   endtask

   task automatic add(input logic wr, input logic [19:0] a, input logic [63:0] wd,
                      input logic [7:0] t, input logic [63:0] ed, input logic ee);
      vec_t v;
      v.wr = wr; v.addr = a; v.wdata = wd; v.tag = t; v.exp_data = ed; v.exp_err = ee;
      vecs.push_back(v);
   endtask

   task automatic do_read(input logic [19:0] a, input logic [7:0] t,
                          input logic [63:0] ed, input logic ee, input string name);
      rsp_ready = 1'b1; req_valid = 1'b1; req_write = 1'b0;
      req_addr = a; req_tag = t; req_wdata = 64'd0;
      #1 chk1({name, " ready"}, req_ready, 1'b1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk1({name, " valid"}, rsp_valid, 1'b1);
      chk({name, " data"}, rsp_data, ed);
      chk({name, " tag"}, {56'd0, rsp_tag}, {56'd0, t});
      chk1({name, " err"}, rsp_err, ee);
   endtask

   task automatic do_write(input logic [19:0] a, input logic [63:0] wd, input string name);
      rsp_ready = 1'b1; req_valid = 1'b1; req_write = 1'b1;
      req_addr = a; req_wdata = wd; req_tag = 8'd0;
      #1 chk1({name, " ready"}, req_ready, 1'b1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk1({name, " no completion"}, rsp_valid, 1'b0);
   endtask

   function automatic logic [63:0] dfh_exp(input int k);
      case (k)
         0:       return DFH0;
         1:       return DFH1;
         default: return DFH2;
      endcase
   endfunction

   task automatic model_read(input logic [19:0] a, input logic [7:0] t);
      cpl_t c;
      int   k;
      k = int'(a[19:12]);
      c.t = t; c.e = 1'b0; c.d = 64'd0;
      if (k >= 3) begin
         c.d = ONES; c.e = 1'b1;
      end else if (a[2:0] != 3'b000) begin
         c.e = 1'b1;
      end else begin
         case (a[11:0])
            12'h000: begin
               c.d = dfh_exp(k);
               if (m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k] = m_cnt[k] + 32'd1;
            end
            12'h008: c.d = m_scr[k];
            12'h010: c.d = {32'd0, m_cnt[k]};
            default: c.d = 64'd0;
         endcase
      end
      exp_q.push_back(c);
   endtask

   task automatic model_write(input logic [19:0] a, input logic [63:0] wd);
      int k;
      k = int'(a[19:12]);
      if (k < 3 && a[11:0] == 12'h008) m_scr[k] = wd;
      else if (k < 3 && a[11:0] == 12'h010) m_cnt[k] = 32'd0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 20'd0;
      req_wdata = 64'd0; req_tag = 8'd0; rsp_ready = 1'b1;

      // counter, chain walk, scratch, other offsets, error cases
      add(1'b0, 20'h02000, 64'd0, 8'h10, DFH2, 1'b0);
      add(1'b0, 20'h02000, 64'd0, 8'h11, DFH2, 1'b0);
      add(1'b0, 20'h02000, 64'd0, 8'h12, DFH2, 1'b0);
      add(1'b0, 20'h02010, 64'd0, 8'h13, 64'd3, 1'b0);
      add(1'b1, 20'h02010, 64'h1234, 8'h00, 64'd0, 1'b0);
      add(1'b0, 20'h02010, 64'd0, 8'h14, 64'd0, 1'b0);
      add(1'b0, 20'h00010, 64'd0, 8'h15, 64'd0, 1'b0);
      add(1'b0, 20'h00000, 64'd0, 8'h01, DFH0, 1'b0);
      add(1'b0, 20'h01000, 64'd0, 8'h02, DFH1, 1'b0);
      add(1'b0, 20'h02000, 64'd0, 8'h03, DFH2, 1'b0);
      add(1'b1, 20'h01008, 64'hDEAD_BEEF_0123_4567, 8'h00, 64'd0, 1'b0);
      add(1'b0, 20'h01008, 64'd0, 8'h20, 64'hDEAD_BEEF_0123_4567, 1'b0);
      add(1'b0, 20'h00008, 64'd0, 8'h21, 64'd0, 1'b0);
      add(1'b1, 20'h00000, 64'd0, 8'h00, 64'd0, 1'b0);
      add(1'b0, 20'h00000, 64'd0, 8'h22, DFH0, 1'b0);
      add(1'b0, 20'h03000, 64'd0, 8'h5A, ONES, 1'b1);
      add(1'b0, 20'h01004, 64'd0, 8'h23, 64'd0, 1'b1);
      add(1'b1, 20'h03008, 64'hFFFF_0000_FFFF_0000, 8'h00, 64'd0, 1'b0);
      add(1'b0, 20'h01008, 64'd0, 8'h24, 64'hDEAD_BEEF_0123_4567, 1'b0);
      add(1'b0, 20'h00008, 64'd0, 8'h25, 64'd0, 1'b0);
      add(1'b0, 20'h00010, 64'd0, 8'h26, 64'd2, 1'b0);
      add(1'b0, 20'h00018, 64'd0, 8'h27, 64'd0, 1'b0);
      add(1'b1, 20'h01018, 64'h5555, 8'h00, 64'd0, 1'b0);
      add(1'b0, 20'h01018, 64'd0, 8'h28, 64'd0, 1'b0);
      add(1'b0, 20'h02010, 64'd0, 8'h29, 64'd1, 1'b0);

      #2;
      chk1("reset rsp_valid", rsp_valid, 1'b0);
      chk("reset rsp_data", rsp_data, 64'd0);
      chk("reset rsp_tag", {56'd0, rsp_tag}, 64'd0);
      chk1("reset rsp_err", rsp_err, 1'b0);
      chk1("reset req_ready", req_ready, 1'b1);
      #10 rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].wr)
            do_write(vecs[i].addr, vecs[i].wdata, $sformatf("vec%0d", i));
         else
            do_read(vecs[i].addr, vecs[i].tag, vecs[i].exp_data, vecs[i].exp_err,
                    $sformatf("vec%0d", i));
      end
      req_valid = 1'b0;
      @(posedge clk); #1;

      // backpressure: first completion held while the second read waits
      rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0;
      req_addr = 20'h00000; req_tag = 8'hA1;
      @(posedge clk); #1;
      req_addr = 20'h01000; req_tag = 8'hA2;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk1($sformatf("bp%0d req_ready", i), req_ready, 1'b0);
         chk1($sformatf("bp%0d valid", i), rsp_valid, 1'b1);
         chk($sformatf("bp%0d data", i), rsp_data, DFH0);
         chk($sformatf("bp%0d tag", i), {56'd0, rsp_tag}, 64'hA1);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      #1 chk1("bp release ready", req_ready, 1'b1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk1("bp second valid", rsp_valid, 1'b1);
      chk("bp second data", rsp_data, DFH1);
      chk("bp second tag", {56'd0, rsp_tag}, 64'hA2);
      @(posedge clk); #1;
      chk1("bp no duplicate", rsp_valid, 1'b0);
      do_read(20'h01010, 8'h30, 64'd2, 1'b0, "bp cnt1");
      do_read(20'h00010, 8'h31, 64'd3, 1'b0, "bp cnt0");

      // reset with a completion pending and SCRATCH nonzero
      do_write(20'h02008, 64'hA5A5_5A5A_0F0F_F0F0, "rst prep wr");
      do_read(20'h02008, 8'h33, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, "rst prep rd");
      rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0;
      req_addr = 20'h00000; req_tag = 8'h77;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk1("rst pending", rsp_valid, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk1("rst async valid", rsp_valid, 1'b0);
      chk1("rst async ready", req_ready, 1'b1);
      chk("rst async data", rsp_data, 64'd0);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 20'h02008; req_wdata = 64'h1234_5678;
      @(posedge clk); @(posedge clk); #1;
      req_valid = 1'b0; rst_n = 1'b1;
      #1 chk1("rst no replay", rsp_valid, 1'b0);
      do_read(20'h02008, 8'h40, 64'd0, 1'b0, "post rst scr2");
      do_read(20'h00010, 8'h41, 64'd0, 1'b0, "post rst cnt0");
      do_read(20'h01008, 8'h42, 64'd0, 1'b0, "post rst scr1");
      do_read(20'h02010, 8'h43, 64'd0, 1'b0, "post rst cnt2");
      req_valid = 1'b0;
      @(posedge clk); #1;

      // randomized traffic against the reference model
      for (int k = 0; k < 3; k++) begin
         m_scr[k] = 64'd0;
         m_cnt[k] = 32'd0;
      end
      for (int c = 0; c < 400; c++) begin
         int   r;
         logic exp_rdy;
         cpl_t f;
         r = $urandom_range(0, 4);
         req_valid = ($urandom_range(0, 3) != 0);
         req_write = ($urandom_range(0, 2) == 0);
         rsp_ready = ($urandom_range(0, 3) != 0);
         req_addr  = {(r == 4) ? 8'hFF : 8'(r), offs[$urandom_range(0, 5)]};
         req_wdata = {$urandom, $urandom};
         req_tag   = 8'($urandom);
         #1;
         exp_rdy = (exp_q.size() == 0) || rsp_ready;
         chk1($sformatf("rand%0d ready", c), req_ready, exp_rdy);
         if (exp_q.size() > 0) begin
            f = exp_q[0];
            chk1($sformatf("rand%0d valid", c), rsp_valid, 1'b1);
            chk($sformatf("rand%0d data", c), rsp_data, f.d);
            chk($sformatf("rand%0d tag", c), {56'd0, rsp_tag}, {56'd0, f.t});
            chk1($sformatf("rand%0d err", c), rsp_err, f.e);
         end else begin
            chk1($sformatf("rand%0d idle", c), rsp_valid, 1'b0);
         end
         if (rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
         if (req_valid && exp_rdy) begin
            if (req_write) model_write(req_addr, req_wdata);
            else           model_read(req_addr, req_tag);
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      @(posedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dfh_csr_responder.md
DFH_CSR_RESPONDER -- requirements
Module: dfh_csr_responder

Interface
REQ-001 SHALL have parameter NUM_FEAT, default 3, meaning the number of features in the DFH chain (legal range 1..16).
REQ-002 SHALL have parameter FEAT_ID, default {12'h014,12'h001,12'h000}, meaning packed 12-bit feature IDs with feature k at bits [12k+11:12k].
REQ-003 SHALL have parameter FEAT_TYPE, default {4'h3,4'h3,4'h4}, meaning packed 4-bit feature types.
REQ-004 SHALL have parameter FEAT_MAJOR, default {4'h0,4'h0,4'h0}, meaning packed 4-bit major revisions.
REQ-005 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: req_valid  in  1  request present; req_ready  out  1  request accepted when both are high; req_write  in  1  1=write, 0=read; req_addr  in  20  byte address; req_wdata  in  64  write data; req_tag  in  8  read tag.
REQ-007 SHALL have ports: rsp_valid  out  1  read completion valid; rsp_ready  in  1  completion consumed; rsp_data  out  64  read data; rsp_tag  out  8  echoed tag; rsp_err  out  1  decode error.

Function
REQ-008 SHALL place feature k at base k*0x1000, with index = req_addr[19:12] and offset = req_addr[11:0].
REQ-009 SHALL form DFH k as {FEAT_TYPE[k], 8'h0, 4'h0 minor, 7'h0, eol, next[23:0], FEAT_MAJOR[k], FEAT_ID[k]}.
REQ-010 SHALL compute next = 24'h001000 and eol = 0 for k < NUM_FEAT-1, and next = 0 and eol = 1 for the last feature.
REQ-011 SHALL decode offset 0x000 as the DFH register: read-only, and writes are ignored.
REQ-012 SHALL decode offset 0x008 as a 64-bit read/write SCRATCH register, one per feature.
REQ-013 SHALL decode offset 0x010 as a read-only DFH_RD_CNT register, one per feature: {32'h0, cnt[31:0]}.
REQ-014 SHALL read all other offsets within a valid feature as 0 with rsp_err=0, and SHALL ignore writes to them.
REQ-015 SHALL increment cnt of a feature by 1 on each accepted read of that feature's DFH, saturating at 32'hFFFF_FFFF.
REQ-016 SHALL clear cnt to 0 on an accepted write to offset 0x010, regardless of data; a DFH read in the same cycle is not possible because there is one request per cycle.
REQ-017 SHALL return data all-ones with rsp_err=1 for a read whose index >= NUM_FEAT, and SHALL ignore a write to such an address.
REQ-018 SHALL return data 0 with rsp_err=1 for a read with req_addr[2:0] != 0, and SHALL ignore an unaligned write.
REQ-019 SHALL drive req_ready = !rsp_valid || rsp_ready, for reads and writes alike.
REQ-020 SHALL produce a read accepted in cycle N as rsp_valid=1 in cycle N+1, with data, tag and err registered.
REQ-021 SHALL hold rsp_valid, rsp_data, rsp_tag and rsp_err stable while rsp_valid && !rsp_ready.
REQ-022 SHALL deassert rsp_valid after a completion is consumed unless a new read is accepted in the same cycle, giving back-to-back throughput of one read per cycle.
REQ-023 SHALL generate no completion for writes; a write accepted in cycle N updates state at the end of cycle N.
REQ-024 SHALL make a write accepted in cycle N visible to a read accepted in cycle N+1.
REQ-025 SHALL sample the counter value for a read of DFH_RD_CNT before any increment from the same access; a read of DFH increments only that feature's cnt.

Reset
REQ-026 SHALL asynchronously force, while rst_n=0: rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=0, all SCRATCH=0, all cnt=0.
REQ-027 SHALL hold req_ready=1 during reset, because rsp_valid=0; requests presented while rst_n=0 SHALL have no effect.
REQ-028 SHALL discard a completion that is pending when reset asserts mid-operation, and SHALL not replay it after reset.
REQ-029 SHALL accept a request on the first rising edge after rst_n deasserts.

Verification
REQ-030 Chain walk, defaults, rsp_ready=1: reads 0x00000 -> 0x4000_0000_1000_0000; 0x01000 -> 0x3000_0000_1000_0001; 0x02000 -> 0x3000_0100_0000_0014 (eol=1), each err=0 and one cycle after acceptance.
REQ-031 Scratch: write 0x01008=0xDEAD_BEEF_0123_4567, then read 0x01008 next cycle -> same value; read 0x00008 -> 0; write 0x00000=0 then read 0x00000 -> DFH unchanged.
REQ-032 Counter: read 0x02000 three times, read 0x02010 -> 3; write 0x02010, read 0x02010 -> 0; read 0x00010 -> 0.
REQ-033 Errors: read 0x03000 tag 0x5A -> all-ones, err=1, tag 0x5A; read 0x01004 -> 0, err=1; write 0x03008 -> no completion and no state change.
REQ-034 Backpressure: rsp_ready=0 for 4 cycles with reads to 0x00000 then 0x01000 pending -> first completion held stable and req_ready=0; rsp_ready=1 -> completions delivered in order with no loss or duplication.
REQ-035 Reset mid-operation: pulse rst_n low with a completion pending and SCRATCH nonzero -> rsp_valid=0 immediately, SCRATCH and counters read 0 afterwards.
